regfile_sb: RTL and testbench

Parametrised register file with two combinational read ports, one write port, optional hardwired-zero register 0, optional write-to-read bypass, and a per-register pending-write scoreboard. It sits in the processor datapath between decode (read/issue) and writeback. It generalises the fixed 8×8-bit file in width and depth, and adds hazard tracking so decode can stall on registers with outstanding writes.

---
 rtl/regfile_sb_pkg.sv | 15 +
 rtl/regfile_scoreboard.sv | 57 +++++
 rtl/regfile_sb.sv | 76 +++++++
 tb/tb_regfile_sb.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/regfile_sb_pkg.sv
// Shared datapath constants for the register file slice.
//   DW_DEF / AW_DEF : processor-wide default data and address widths
//   REG_ZERO        : index of the hardwired-zero register
//   nregs()         : register count for a given address width
package regfile_sb_pkg;

  localparam int DW_DEF   = 8;
  localparam int AW_DEF   = 3;
  localparam int REG_ZERO = 0;

  function automatic int nregs(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, set at issue, cleared at
// writeback, looked up per read port.
//   clk, rst          : clock, synchronous active-high reset
//   regwrite, wa      : writeback clears pend[wa]
//   busy_set, busy_wa : issue sets pend[busy_wa]
//   ra1, ra2          : lookup addresses
//   busy1, busy2      : outstanding-write flags for ra1 / ra2
module regfile_scoreboard import regfile_sb_pkg::*; #(
  parameter int AW      = AW_DEF,
  parameter int ZERO_R0 = 1,
  parameter int BYPASS  = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          regwrite,
  input  logic [AW-1:0] wa,
  input  logic          busy_set,
  input  logic [AW-1:0] busy_wa,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic          busy1,
  output logic          busy2
);

  localparam int            NREGS = nregs(AW);
  localparam logic [AW-1:0] R0    = AW'(REG_ZERO);

  logic [NREGS-1:0] pend_q, pend_d;

  // Clear first, then set: a newer producer issuing in the same cycle as an
  // older writeback to the same register keeps the register pending.
  always_comb begin
    pend_d = pend_q;
    if (regwrite) pend_d[wa] = 1'b0;
    if (busy_set) pend_d[busy_wa] = 1'b1;
    if (ZERO_R0 != 0) pend_d[R0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) pend_q <= '0;
    else     pend_q <= pend_d;
  end

  // A write landing this cycle is forwarded, so the reader need not stall.
  always_comb begin
    busy1 = pend_q[ra1];
    if (BYPASS != 0 && regwrite && wa == ra1) busy1 = 1'b0;
    if (ZERO_R0 != 0 && ra1 == R0) busy1 = 1'b0;
  end

  always_comb begin
    busy2 = pend_q[ra2];
    if (BYPASS != 0 && regwrite && wa == ra2) busy2 = 1'b0;
    if (ZERO_R0 != 0 && ra2 == R0) busy2 = 1'b0;
  end

endmodule

// File: rtl/regfile_sb.sv
// Register file with two combinational read ports, one write port, optional
// hardwired-zero r0, optional write-to-read bypass and a pending-write
// scoreboard for decode stalls.
//   clk, rst          : clock, synchronous active-high reset
//   regwrite, wa, wd  : write port
//   ra1/rd1, ra2/rd2  : read ports (combinational)
//   busy_set, busy_wa : mark register pending at issue
//   busy1, busy2      : ra1 / ra2 have an outstanding write
module regfile_sb import regfile_sb_pkg::*; #(
  parameter int DW      = DW_DEF,
  parameter int AW      = AW_DEF,
  parameter int ZERO_R0 = 1,
  parameter int BYPASS  = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          regwrite,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic [DW-1:0] rd1,
  output logic [DW-1:0] rd2,
  input  logic          busy_set,
  input  logic [AW-1:0] busy_wa,
  output logic          busy1,
  output logic          busy2
);

  localparam int            NREGS = nregs(AW);
  localparam logic [AW-1:0] R0    = AW'(REG_ZERO);

  logic [DW-1:0] mem_q [NREGS];
  logic [DW-1:0] mem_d [NREGS];

  always_comb begin
    mem_d = mem_q;
    if (regwrite && !(ZERO_R0 != 0 && wa == R0)) mem_d[wa] = wd;
  end

  always_ff @(posedge clk) begin
    if (rst) mem_q <= '{default: '0};
    else     mem_q <= mem_d;
  end

  // r0 check is last so it overrides a bypass hit on address 0.
  always_comb begin
    rd1 = mem_q[ra1];
    if (BYPASS != 0 && regwrite && wa == ra1) rd1 = wd;
    if (ZERO_R0 != 0 && ra1 == R0) rd1 = '0;
  end

  always_comb begin
    rd2 = mem_q[ra2];
    if (BYPASS != 0 && regwrite && wa == ra2) rd2 = wd;
    if (ZERO_R0 != 0 && ra2 == R0) rd2 = '0;
  end

  regfile_scoreboard #(
    .AW      (AW),
    .ZERO_R0 (ZERO_R0),
    .BYPASS  (BYPASS)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .regwrite (regwrite),
    .wa       (wa),
    .busy_set (busy_set),
    .busy_wa  (busy_wa),
    .ra1      (ra1),
    .ra2      (ra2),
    .busy1    (busy1),
    .busy2    (busy2)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb with default parameters
// (DW=8, AW=3, ZERO_R0=1, BYPASS=1).
module tb_regfile_sb;

  logic       clk = 1'b0;
  logic       rst;
  logic       regwrite;
  logic [2:0] wa;
  logic [7:0] wd;
  logic [2:0] ra1, ra2;
  logic [7:0] rd1, rd2;
  logic       busy_set;
  logic [2:0] busy_wa;
  logic       busy1, busy2;

  int checks   = 0;
  int failures = 0;

  regfile_sb dut (
    .clk      (clk),
    .rst      (rst),
    .regwrite (regwrite),
    .wa       (wa),
    .wd       (wd),
    .ra1      (ra1),
    .ra2      (ra2),
    .rd1      (rd1),
    .rd2      (rd2),
    .busy_set (busy_set),
    .busy_wa  (busy_wa),
    .busy1    (busy1),
    .busy2    (busy2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; regwrite = 1'b0; wa = '0; wd = '0;
    ra1 = '0; ra2 = '0; busy_set = 1'b0; busy_wa = '0;
    tick(); tick();
    rst = 1'b0;
    #1;

    // Reset state on every address, both ports
    for (int a = 0; a < 8; a++) begin
      ra1 = 3'(a); ra2 = 3'(7 - a);
      #1;
      chk($sformatf("rst_rd1_a%0d", a), rd1, 0);
      chk($sformatf("rst_rd2_a%0d", a), rd2, 0);
      chk($sformatf("rst_busy1_a%0d", a), busy1, 0);
      chk($sformatf("rst_busy2_a%0d", a), busy2, 0);
    end

    // Write 0x02 to r4, bypass in the same cycle
    regwrite = 1'b1; wa = 3'd4; wd = 8'h02; ra1 = 3'd4; ra2 = 3'd3;
    #1;
    chk("byp_rd1_r4", rd1, 8'h02);
    chk("nobyp_rd2_r3", rd2, 8'h00);
    tick();
    regwrite = 1'b0; ra1 = 3'd4; ra2 = 3'd4;
    #1;
    chk("wr_rd1_r4", rd1, 8'h02);
    chk("wr_rd2_r4", rd2, 8'h02);
    regwrite = 1'b1; wa = 3'd4; wd = 8'h17;
    tick();
    regwrite = 1'b0;
    #1;
    chk("ovw_rd1_r4", rd1, 8'h17);
    chk("ovw_rd2_r4", rd2, 8'h17);

    // Hardwired zero register
    regwrite = 1'b1; wa = 3'd0; wd = 8'hFF; ra1 = 3'd0;
    #1;
    chk("r0_byp_rd1", rd1, 8'h00);
    tick();
    regwrite = 1'b0;
    #1;
    chk("r0_rd1", rd1, 8'h00);
    busy_set = 1'b1; busy_wa = 3'd0;
    tick();
    busy_set = 1'b0;
    #1;
    chk("r0_busy1", busy1, 0);

    // Scoreboard set, then writeback clears with bypass masking
    busy_set = 1'b1; busy_wa = 3'd5;
    tick();
    busy_set = 1'b0; ra2 = 3'd5;
    #1;
    chk("sb_busy2_set", busy2, 1);
    tick();
    chk("sb_busy2_hold", busy2, 1);
    regwrite = 1'b1; wa = 3'd5; wd = 8'h33;
    #1;
    chk("sb_busy2_wrcyc", busy2, 0);
    chk("sb_rd2_wrcyc", rd2, 8'h33);
    tick();
    regwrite = 1'b0;
    #1;
    chk("sb_busy2_after", busy2, 0);
    chk("sb_rd2_after", rd2, 8'h33);

    // Same-cycle set and clear on r3: set wins
    regwrite = 1'b1; wa = 3'd3; wd = 8'h4C; busy_set = 1'b1; busy_wa = 3'd3; ra1 = 3'd3;
    #1;
    chk("sc_busy1_wrcyc", busy1, 0);
    chk("sc_rd1_wrcyc", rd1, 8'h4C);
    tick();
    regwrite = 1'b0; busy_set = 1'b0;
    #1;
    chk("sc_busy1_next", busy1, 1);
    chk("sc_rd1_next", rd1, 8'h4C);

    // Set and clear on different registers: both take effect
    regwrite = 1'b1; wa = 3'd3; wd = 8'h5D; busy_set = 1'b1; busy_wa = 3'd1;
    tick();
    regwrite = 1'b0; busy_set = 1'b0; ra1 = 3'd3; ra2 = 3'd1;
    #1;
    chk("diff_busy1_r3", busy1, 0);
    chk("diff_rd1_r3", rd1, 8'h5D);
    chk("diff_busy2_r1", busy2, 1);
    ra1 = 3'd1;
    #1;
    chk("same_busy1_r1", busy1, 1);
    chk("same_rd_eq", {rd1, rd2}, 16'h0000);

    // Mid-operation reset discards data and pending state
    regwrite = 1'b1; wa = 3'd2; wd = 8'hAA; busy_set = 1'b1; busy_wa = 3'd6;
    tick();
    regwrite = 1'b0; busy_set = 1'b0; ra1 = 3'd2; ra2 = 3'd6;
    #1;
    chk("pre_rst_rd1_r2", rd1, 8'hAA);
    chk("pre_rst_busy2_r6", busy2, 1);
    rst = 1'b1; regwrite = 1'b1; wa = 3'd2; wd = 8'h55;
    busy_set = 1'b1; busy_wa = 3'd2;
    tick();
    rst = 1'b0; regwrite = 1'b0; busy_set = 1'b0;
    #1;
    chk("post_rst_rd1_r2", rd1, 8'h00);
    chk("post_rst_busy1_r2", busy1, 0);
    chk("post_rst_busy2_r6", busy2, 0);
    ra1 = 3'd4; ra2 = 3'd1;
    #1;
    chk("post_rst_rd1_r4", rd1, 8'h00);
    chk("post_rst_busy2_r1", busy2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
